nibble_serial_mult16: RTL and testbench

NIBBLE_SERIAL_MULT16 -- requirements
Module: nibble_serial_mult16

---
 rtl/nibble_serial_mult16_pkg.sv | 32 +++
 rtl/karatsuba4.sv | 28 ++
 rtl/nibble_serial_mult16.sv | 124 ++++++++++++
 tb/tb_nibble_serial_mult16.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_mult16_pkg.sv
// Shared constants, state encoding and nibble helpers for the nibble-serial 16x16 multiplier.
package nibble_serial_mult16_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned NUM_STEPS = 16;
  localparam int unsigned OPND_W    = 16;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned STEP_W    = 4;
  localparam int unsigned PART_W    = 2 * NIBBLE_W;
  localparam int unsigned SHIFT_W   = 5;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic [NIBBLE_W-1:0] get_nibble(input logic [OPND_W-1:0] v,
                                                     input logic [1:0]        idx);
    return v[{idx, 2'b00} +: NIBBLE_W];
  endfunction

  // Weight of a partial product, in bits: 4 * (ia + ib).
  function automatic logic [SHIFT_W-1:0] part_shift(input logic [1:0] ia,
                                                    input logic [1:0] ib);
    return {3'(ia) + 3'(ib), 2'b00};
  endfunction

endpackage

// File: rtl/karatsuba4.sv
// Combinational 4x4 -> 8 unsigned multiplier built from one level of Karatsuba on 2-bit halves.
module karatsuba4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [1:0] al, ah, bl, bh;
  logic [3:0] z0, z2;
  logic [2:0] sa, sb;
  logic [5:0] z1m, z1;

  assign al = a[1:0];
  assign ah = a[3:2];
  assign bl = b[1:0];
  assign bh = b[3:2];

  assign z0  = {2'b00, al} * {2'b00, bl};
  assign z2  = {2'b00, ah} * {2'b00, bh};
  assign sa  = {1'b0, ah} + {1'b0, al};
  assign sb  = {1'b0, bh} + {1'b0, bl};
  assign z1m = {3'b000, sa} * {3'b000, sb};
  // Cross term ah*bl + al*bh never exceeds 18, so 6 bits cannot underflow here.
  assign z1  = z1m - {2'b00, z2} - {2'b00, z0};

  assign p = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};

endmodule

// File: rtl/nibble_serial_mult16.sv
// Unsigned 16x16 multiplier that sums the sixteen 4x4 nibble products, one per cycle.
module nibble_serial_mult16
  import nibble_serial_mult16_pkg::*;
#(
  parameter int unsigned REG_PROD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod
);

  state_e state_q, state_d;

  logic [OPND_W-1:0]  a_q, b_q;
  logic [STEP_W-1:0]  step_q;
  logic [PROD_W-1:0]  acc_q;
  logic [PART_W-1:0]  pipe_part_q;
  logic [SHIFT_W-1:0] pipe_shift_q;
  logic               pipe_vld_q;

  logic [1:0]          ia, ib;
  logic [NIBBLE_W-1:0] x, y;
  logic [PART_W-1:0]   part;
  logic [SHIFT_W-1:0]  cur_shift;
  logic                accept;
  logic                running;

  logic [PART_W-1:0]  add_part;
  logic [SHIFT_W-1:0] add_shift;
  logic               add_en;
  logic [PROD_W-1:0]  addend;

  assign accept  = in_valid && (state_q == StIdle);
  assign running = (state_q == StRun);

  assign ia        = step_q[3:2];
  assign ib        = step_q[1:0];
  assign x         = get_nibble(a_q, ia);
  assign y         = get_nibble(b_q, ib);
  assign cur_shift = part_shift(ia, ib);

  karatsuba4 u_mult (
    .a (x),
    .b (y),
    .p (part)
  );

  // Source of the accumulate: live multiplier output or the one-cycle-delayed copy.
  always_comb begin
    add_part  = part;
    add_shift = cur_shift;
    add_en    = running;
    if (REG_PROD != 0) begin
      add_part  = pipe_part_q;
      add_shift = pipe_shift_q;
      add_en    = pipe_vld_q;
    end
  end

  assign addend = PROD_W'(add_part) << add_shift;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun: begin
        if (step_q == LAST_STEP) state_d = (REG_PROD != 0) ? StFlush : StDone;
      end
      StFlush: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      step_q       <= '0;
      acc_q        <= '0;
      pipe_part_q  <= '0;
      pipe_shift_q <= '0;
      pipe_vld_q   <= 1'b0;
    end else if (accept) begin
      a_q          <= a;
      b_q          <= b;
      step_q       <= '0;
      acc_q        <= '0;
      pipe_part_q  <= '0;
      pipe_shift_q <= '0;
      pipe_vld_q   <= 1'b0;
    end else begin
      // Counter wraps 15 -> 0 on the same edge that leaves RUN.
      if (running) begin
        step_q <= step_q + 1'b1;
      end
      if (add_en) begin
        acc_q <= acc_q + addend;
      end
      pipe_part_q  <= part;
      pipe_shift_q <= cur_shift;
      pipe_vld_q   <= running;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign prod      = acc_q;

endmodule

// File: tb/tb_nibble_serial_mult16.sv
// Directed and random checks of both REG_PROD variants against plain a*b arithmetic.
module tb_nibble_serial_mult16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [15:0] a_v       [2];
  logic [15:0] b_v       [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] prod      [2];

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_mult16 #(.REG_PROD(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .a         (a_v[0]),
    .b         (b_v[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .prod      (prod[0])
  );

  nibble_serial_mult16 #(.REG_PROD(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .a         (a_v[1]),
    .b         (b_v[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .prod      (prod[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] av, input logic [15:0] bv);
    return 32'(av) * 32'(bv);
  endfunction

  // Edges after the accept edge until out_valid is seen; bounded so a dead DUT cannot hang.
  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (out_valid[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic start_op(input int i, input logic [15:0] av, input logic [15:0] bv);
    a_v[i]      = av;
    b_v[i]      = bv;
    in_valid[i] = 1'b1;
    chk($sformatf("ready_before_accept[%0d]", i), 32'(in_ready[i]), 32'd1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    chk($sformatf("ready_after_accept[%0d]", i), 32'(in_ready[i]), 32'd0);
  endtask

  // Latency counts edges from the accept edge to the first edge at which the result can be taken.
  task automatic check_result(input int i, input string tag, input logic [31:0] exp);
    int n;
    wait_valid(i, n);
    chk($sformatf("%s_latency[%0d]", tag, i), 32'(n + 1), 32'(17 + i));
    chk($sformatf("%s_prod[%0d]", tag, i), prod[i], exp);
  endtask

  task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                        input bit glitch, input string tag);
    logic [31:0] exp;
    exp          = ref_prod(av, bv);
    out_ready[i] = 1'b1;
    start_op(i, av, bv);
    if (glitch) begin
      a_v[i] = 16'hFFFF;
      b_v[i] = 16'hFFFF;
    end
    check_result(i, tag, exp);
    @(negedge clk);
    chk($sformatf("%s_ready_after_hs[%0d]", tag, i), 32'(in_ready[i]), 32'd1);
    chk($sformatf("%s_valid_after_hs[%0d]", tag, i), 32'(out_valid[i]), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] hold;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a_v[i] = '0;   b_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      chk($sformatf("reset_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("reset_prod[%0d]", i), prod[i], 32'd0);
      rst[i] = 1'b0;
    end
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      run_op(i, 16'h1234, 16'h5678, 1'b0, "basic");
      chk($sformatf("basic_const[%0d]", i), prod[i], 32'h06260060);
      run_op(i, 16'hFFFF, 16'hFFFF, 1'b0, "max");
      chk($sformatf("max_const[%0d]", i), prod[i], 32'hFFFE0001);
      chk($sformatf("hold_idle[%0d]", i), prod[i], 32'hFFFE0001);
      run_op(i, 16'h0000, 16'hBEEF, 1'b0, "zero");
      run_op(i, 16'h0003, 16'h0005, 1'b1, "glitch");
      chk($sformatf("glitch_const[%0d]", i), prod[i], 32'h0000000F);

      // Backpressure: result must hold while in_valid pulses are ignored.
      out_ready[i] = 1'b0;
      start_op(i, 16'h00FF, 16'h0100);
      check_result(i, "bp", 32'h0000FF00);
      hold = prod[i];
      for (int k = 0; k < 5; k++) begin
        in_valid[i] = (k % 2 == 0);
        a_v[i] = 16'($urandom);
        b_v[i] = 16'($urandom);
        @(negedge clk);
        chk($sformatf("bp_prod_stable[%0d]", i), prod[i], hold);
        chk($sformatf("bp_in_ready[%0d]", i), 32'(in_ready[i]), 32'd0);
        chk($sformatf("bp_out_valid[%0d]", i), 32'(out_valid[i]), 32'd1);
      end
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_release_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      @(negedge clk);
      chk($sformatf("bp_not_queued[%0d]", i), 32'(in_ready[i]), 32'd1);

      // Reset in the middle of RUN at step 8.
      start_op(i, 16'h1234, 16'h5678);
      repeat (8) @(negedge clk);
      rst[i] = 1'b1;
      @(negedge clk);
      rst[i] = 1'b0;
      chk($sformatf("midrst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      chk($sformatf("midrst_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("midrst_prod[%0d]", i), prod[i], 32'd0);
      repeat (20) @(negedge clk);
      chk($sformatf("midrst_discarded[%0d]", i), 32'(out_valid[i]), 32'd0);
      run_op(i, 16'h0007, 16'h0009, 1'b0, "after_rst");
      chk($sformatf("after_rst_const[%0d]", i), prod[i], 32'h0000003F);

      // Back-to-back with in_valid held high; second pair waits for the first handshake.
      out_ready[i] = 1'b1;
      a_v[i] = 16'hA5C3;
      b_v[i] = 16'h3C5A;
      in_valid[i] = 1'b1;
      @(negedge clk);
      chk($sformatf("b2b_first_accept[%0d]", i), 32'(in_ready[i]), 32'd0);
      a_v[i] = 16'h8001;
      b_v[i] = 16'h7FFE;
      check_result(i, "b2b_first", ref_prod(16'hA5C3, 16'h3C5A));
      @(negedge clk);
      chk($sformatf("b2b_idle_gap[%0d]", i), 32'(in_ready[i]), 32'd1);
      @(negedge clk);
      chk($sformatf("b2b_second_accept[%0d]", i), 32'(in_ready[i]), 32'd0);
      in_valid[i] = 1'b0;
      check_result(i, "b2b_second", ref_prod(16'h8001, 16'h7FFE));
      @(negedge clk);

      for (int r = 0; r < 6; r++) begin
        run_op(i, 16'($urandom), 16'($urandom), bit'(r % 2), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
